// File: rtl/muacm_pkg.sv
// Shared definitions for the muacm USB CDC-ACM datapath.
// The FIFO word carries the message-end flag alongside each byte.
package muacm_pkg;

  localparam int MUACM_EP_MPS = 64;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_word_t;

endpackage

// File: rtl/muacm_ram_sdp.sv
// Simple dual-port RAM, registered write and registered read, no reset.
// Read data holds when rd_en is low so it can act as a pipeline stage.
module muacm_ram_sdp
  import muacm_pkg::*;
#(
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  fifo_word_t            wr_dat,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output fifo_word_t            rd_dat
);

  fifo_word_t mem [1 << DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/muacm_in_fifo.sv
// IN staging FIFO ahead of the USB IN DMA: FWFT, accept at N -> out_valid after N+2, 1 byte/cycle.
// Backpressure: usr_ready drops only when level is full; out holds until out_ready. Also makes flush hints.
module muacm_in_fifo
  import muacm_pkg::*;
#(
  parameter int DEPTH_LOG2 = 7,
  parameter int TIMEOUT_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            usr_data,
  input  logic                  usr_last,
  input  logic                  usr_valid,
  output logic                  usr_ready,
  input  logic                  usr_flush,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  flush_now,
  output logic                  flush_time,
  output logic [DEPTH_LOG2:0]   level
);

  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] LVL_MPS  = (DEPTH_LOG2+1)'(MUACM_EP_MPS);

  logic [DEPTH_LOG2:0]  wr_ptr, rd_ptr, rd_count, flush_ptr;
  logic [DEPTH_LOG2:0]  level_nxt, wr_ptr_nxt, rd_count_nxt;
  logic                 flush_pend, pipe_vld;
  logic [TIMEOUT_W-1:0] idle_cnt;
  fifo_word_t           wr_word, ram_rd, out_q;
  logic                 wr_en, out_hs, ram_has, load, rd_en, flush_set, flush_clr;

  assign usr_ready = ~rst & (level != LVL_FULL);
  assign wr_en     = usr_valid & usr_ready;
  assign out_hs    = out_valid & out_ready;
  assign ram_has   = (wr_ptr != rd_ptr);

  // RAM read register is a prefetch stage feeding the output register.
  assign load  = pipe_vld & (~out_valid | out_ready);
  assign rd_en = ram_has & (~pipe_vld | load);

  assign wr_word  = '{last: usr_last, data: usr_data};
  assign out_data = out_q.data;
  assign out_last = out_q.last;

  always_comb begin
    level_nxt    = level;
    wr_ptr_nxt   = wr_ptr;
    rd_count_nxt = rd_count;
    if (wr_en)  wr_ptr_nxt   = wr_ptr + 1'b1;
    if (out_hs) rd_count_nxt = rd_count + 1'b1;
    case ({wr_en, out_hs})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  assign flush_set = (usr_flush | (wr_en & usr_last)) & (level_nxt != '0);
  assign flush_clr = out_hs & (rd_count_nxt == flush_ptr);

  muacm_ram_sdp #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_dat  (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_dat  (ram_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_count <= '0;
      level    <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_count <= rd_count_nxt;
      level    <= level_nxt;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld  <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      if (rd_en)     pipe_vld <= 1'b1;
      else if (load) pipe_vld <= 1'b0;
      if (load) begin
        out_q     <= ram_rd;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  // A new flush point overrides a clear landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend <= 1'b0;
      flush_ptr  <= '0;
    end else if (flush_set) begin
      flush_pend <= 1'b1;
      flush_ptr  <= wr_ptr_nxt;
    end else if (flush_clr) begin
      flush_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (wr_en || (level == '0)) begin
      idle_cnt <= '0;
    end else if (idle_cnt != {TIMEOUT_W{1'b1}}) begin
      idle_cnt <= idle_cnt + TIMEOUT_W'(1);
    end
  end

  assign flush_now  = flush_pend | (level >= LVL_MPS);
  assign flush_time = (&idle_cnt) & (level != '0);

endmodule

// File: tb/tb_muacm_in_fifo.sv
// Bench for muacm_in_fifo: directed scenarios plus random traffic, checked by a
// negedge monitor against a queue-based reference of FIFO contents and flush state.
module tb_muacm_in_fifo;

  localparam int DL2   = 7;
  localparam int DEPTH = 1 << DL2;
  localparam int TW    = 4;
  localparam int TMAX  = (1 << TW) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   usr_data;
  logic         usr_last, usr_valid, usr_ready, usr_flush;
  logic [7:0]   out_data;
  logic         out_last, out_valid, out_ready;
  logic         flush_now, flush_time;
  logic [DL2:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: bytes held, handshakes left until the flush point, idle age.
  logic [8:0] sb [$];
  int         pend_left = 0;
  int         idle_age  = 0;
  logic       hold      = 1'b0;
  logic [8:0] hold_w    = '0;

  always #5 clk = ~clk;

  muacm_in_fifo #(.DEPTH_LOG2(DL2), .TIMEOUT_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .usr_data   (usr_data),
    .usr_last   (usr_last),
    .usr_valid  (usr_valid),
    .usr_ready  (usr_ready),
    .usr_flush  (usr_flush),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush_now  (flush_now),
    .flush_time (flush_time),
    .level      (level)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    int         sz;
    logic       hs, acc;
    logic [8:0] exp_w;
    forever begin
      @(negedge clk);
      sz = sb.size();
      if (rst) begin
        sb.delete();
        pend_left = 0;
        idle_age  = 0;
        hold      = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_usr_ready", usr_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", {out_last, out_data}, 0);
        chk("rst_flush_now", flush_now, 0);
        chk("rst_flush_time", flush_time, 0);
      end else begin
        chk("level", level, sz);
        chk("usr_ready", usr_ready, int'(sz != DEPTH));
        chk("flush_now", flush_now, int'(pend_left > 0 || sz >= 64));
        chk("flush_time", flush_time, int'(idle_age == TMAX && sz != 0));
        if (hold) begin
          chk("out_hold_valid", out_valid, 1);
          chk("out_hold_word", {out_last, out_data}, hold_w);
        end
        hs  = out_valid & out_ready;
        acc = usr_valid & usr_ready;
        if (hs) begin
          if (sz == 0) chk("out_unexpected_sb_size", sz, 1);
          else begin
            exp_w = sb.pop_front();
            chk("out_word", {out_last, out_data}, exp_w);
          end
        end
        hold   = out_valid & ~out_ready;
        hold_w = {out_last, out_data};
        if (acc || sz == 0) idle_age = 0;
        else if (idle_age < TMAX) idle_age++;
        if (acc) sb.push_back({usr_last, usr_data});
        if (hs && pend_left > 0) pend_left--;
        if ((usr_flush || (acc && usr_last)) && sb.size() > 0) pend_left = sb.size();
      end
    end
  endtask

  task automatic write_byte(input logic [7:0] d, input logic l, input logic f);
    int   b;
    logic a;
    b = 0;
    a = 1'b0;
    usr_valid = 1'b1;
    usr_data  = d;
    usr_last  = l;
    usr_flush = f;
    while (!a && b < 300) begin
      #3;
      a = usr_ready;
      @(posedge clk);
      #1;
      b++;
    end
    if (!a) chk("write_accept_timeout", int'(a), 1);
    usr_valid = 1'b0;
    usr_last  = 1'b0;
    usr_flush = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    out_ready = 1'b1;
    while (level != 0 && b < 1000) begin
      cyc();
      b++;
    end
    chk("drain_level", level, 0);
  endtask

  initial begin
    int acc_cnt, nb, b;
    rst = 1'b1;
    usr_data = '0; usr_last = 1'b0; usr_valid = 1'b0; usr_flush = 1'b0; out_ready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("ready_after_release", usr_ready, 1);
    cyc();

    // Basic stream with latency check
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      usr_valid = 1'b1;
      usr_data  = 8'(i);
      cyc();
      if (i == 2) chk("lat_n1_valid", out_valid, 0);
      if (i == 3) begin
        chk("lat_n2_valid", out_valid, 1);
        chk("lat_n2_data", out_data, 1);
      end
    end
    usr_valid = 1'b0;
    repeat (6) cyc();
    chk("basic_level", level, 0);
    chk("basic_flush_now", flush_now, 0);
    chk("basic_flush_time", flush_time, 0);

    // Fill to full
    out_ready = 1'b0;
    acc_cnt = 0;
    usr_valid = 1'b1;
    for (int i = 0; i < 130; i++) begin
      usr_data = 8'($urandom);
      #3;
      if (usr_ready) acc_cnt++;
      @(posedge clk);
      #1;
    end
    usr_valid = 1'b0;
    chk("fill_accepts", acc_cnt, DEPTH);
    chk("fill_level", level, DEPTH);
    chk("fill_ready", usr_ready, 0);
    chk("fill_flush_now", flush_now, 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("fill_ready_after_drain1", usr_ready, 1);
    chk("fill_level_after_drain1", level, DEPTH - 1);
    drain();

    // Explicit flush on the 10th byte
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) write_byte(8'($urandom), 1'b0, i == 9);
    chk("flush_set", flush_now, 1);
    chk("flush_level", level, 10);
    out_ready = 1'b1;
    b = 0;
    while (level > 1 && b < 100) begin
      cyc();
      b++;
    end
    chk("flush_hold_before_last", flush_now, 1);
    drain();
    chk("flush_cleared", flush_now, 0);
    out_ready = 1'b0;
    usr_flush = 1'b1;
    cyc();
    usr_flush = 1'b0;
    chk("empty_flush_ignored", flush_now, 0);
    cyc();
    chk("empty_flush_ignored2", flush_now, 0);

    // usr_last on the 3rd byte
    write_byte(8'h31, 1'b0, 1'b0);
    write_byte(8'h32, 1'b0, 1'b0);
    write_byte(8'h33, 1'b1, 1'b0);
    chk("last_flush_set", flush_now, 1);
    out_ready = 1'b1;
    nb = 0;
    b = 0;
    while (level != 0 && b < 50) begin
      #3;
      if (out_valid) begin
        nb++;
        chk("last_flag_pos", out_last, int'(nb == 3));
      end
      @(posedge clk);
      #1;
      b++;
    end
    chk("last_count", nb, 3);
    chk("last_flush_clr", flush_now, 0);

    // Idle timeout
    out_ready = 1'b0;
    write_byte(8'h77, 1'b0, 1'b0);
    for (int k = 1; k <= TMAX; k++) begin
      cyc();
      if (k == TMAX - 1) chk("timeout_early", flush_time, 0);
      if (k == TMAX) chk("timeout_hit", flush_time, 1);
    end
    write_byte(8'h78, 1'b0, 1'b0);
    chk("timeout_cleared_by_write", flush_time, 0);
    repeat (TMAX) cyc();
    chk("timeout_again", flush_time, 1);
    drain();
    chk("timeout_cleared_by_empty", flush_time, 0);

    // Reset while holding 20 bytes with a flush pending
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) write_byte(8'($urandom), i == 19, 1'b0);
    chk("pre_rst_flush_now", flush_now, 1);
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_ready", usr_ready, 0);
    chk("async_rst_flush_now", flush_now, 0);
    chk("async_rst_out_data", out_data, 0);
    cyc();
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    usr_valid = 1'b1;
    usr_data  = 8'hA5;
    cyc();
    usr_valid = 1'b0;
    cyc();
    chk("post_rst_lat_n1", out_valid, 0);
    cyc();
    chk("post_rst_lat_n2", out_valid, 1);
    chk("post_rst_data", out_data, 8'hA5);
    drain();

    // Random traffic: congested phase, then mostly draining
    for (int c = 0; c < 3000; c++) begin
      usr_valid = ($urandom_range(0, 3) != 0);
      usr_data  = 8'($urandom);
      usr_last  = ($urandom_range(0, 7) == 0);
      usr_flush = ($urandom_range(0, 15) == 0);
      out_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ((c % 500) > 460) usr_valid = 1'b0;
      cyc();
    end
    usr_valid = 1'b0;
    usr_last  = 1'b0;
    usr_flush = 1'b0;
    drain();
    repeat (3) cyc();
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
